// File: rtl/tt_lut_responder_pkg.sv
// Shared types and sizing helpers for the truth-table query responder.
package tt_lut_responder_pkg;

  localparam int unsigned N_IN_DEFAULT = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  function automatic int unsigned tbl_size(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/tt_loader.sv
// Serial truth-table loader: LSB-first bit capture, running minterm count, load_done pulse.
module tt_loader
  import tt_lut_responder_pkg::*;
#(
  parameter  int unsigned N_IN = N_IN_DEFAULT,
  localparam int unsigned TBL  = tbl_size(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic             load_bit,
  output state_t           state,
  output logic             load_ready,
  output logic             load_done,
  output logic [N_IN:0]    minterm_cnt,
  output logic [TBL-1:0]   tbl
);

  logic [N_IN-1:0] cnt;
  logic [N_IN:0]   run;
  logic [N_IN:0]   run_next;

  assign run_next   = run + {{N_IN{1'b0}}, load_bit};
  assign load_ready = (state == LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      tbl         <= '0;
      cnt         <= '0;
      run         <= '0;
      minterm_cnt <= '0;
      load_done   <= 1'b0;
    end else begin
      load_done <= 1'b0;
      // load_start has priority: it restarts the load and drops a coincident bit
      if (load_start) begin
        state       <= LOAD;
        cnt         <= '0;
        run         <= '0;
        minterm_cnt <= '0;
      end else if (state == LOAD && load_valid) begin
        tbl[cnt] <= load_bit;
        cnt      <= cnt + 1'b1;
        run      <= run_next;
        if (cnt == '1) begin
          state       <= READY;
          load_done   <= 1'b1;
          minterm_cnt <= run_next;
        end
      end
    end
  end

endmodule

// File: rtl/tt_lut_responder.sv
// Truth-table responder: serial table load, then 1-cycle-latency valid/ready queries.
module tt_lut_responder
  import tt_lut_responder_pkg::*;
#(
  parameter int unsigned N_IN = N_IN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start,
  input  logic            load_valid,
  input  logic            load_bit,
  output logic            load_ready,
  output logic            load_done,
  output logic [N_IN:0]   minterm_cnt,
  input  logic            q_valid,
  input  logic [N_IN-1:0] q_args,
  output logic            q_ready,
  output logic            r_valid,
  output logic            r_res,
  output logic [N_IN-1:0] r_args,
  input  logic            r_ready
);

  localparam int unsigned TBL = tbl_size(N_IN);

  state_t         state;
  logic [TBL-1:0] tbl;
  logic           q_fire;

  tt_loader #(.N_IN(N_IN)) u_loader (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_bit    (load_bit),
    .state       (state),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .minterm_cnt (minterm_cnt),
    .tbl         (tbl)
  );

  assign q_ready = (state == READY) && (!r_valid || r_ready);
  assign q_fire  = q_valid && q_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_res   <= 1'b0;
      r_args  <= '0;
    end else if (q_fire) begin
      r_valid <= 1'b1;
      r_res   <= tbl[q_args];
      r_args  <= q_args;
    end else if (r_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tt_lut_responder.sv
// Scoreboard bench for tt_lut_responder: load, query, backpressure, restart and collision scenarios.
module tb_tt_lut_responder;

  localparam int unsigned N = 5;

  logic         clk = 1'b0;
  logic         rst, load_start, load_valid, load_bit;
  logic         load_ready, load_done;
  logic [N:0]   minterm_cnt;
  logic         q_valid, q_ready, r_valid, r_res, r_ready;
  logic [N-1:0] q_args, r_args;

  typedef struct packed {
    logic         res;
    logic [N-1:0] args;
  } resp_t;

  resp_t       sbq[$];
  logic [31:0] model_tbl;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  tt_lut_responder #(.N_IN(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_bit    (load_bit),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .minterm_cnt (minterm_cnt),
    .q_valid     (q_valid),
    .q_args      (q_args),
    .q_ready     (q_ready),
    .r_valid     (r_valid),
    .r_res       (r_res),
    .r_args      (r_args),
    .r_ready     (r_ready)
  );

  // Stimulus only: 32-bit LSB-first load, optionally with a bit coinciding with load_start.
  task automatic load_word(input logic [31:0] w, input logic collide,
                           output int early_done, output int ready_low,
                           output logic done_after, output logic [N:0] cnt_after);
    @(negedge clk);
    load_start = 1'b1; load_valid = collide; load_bit = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    early_done = 0; ready_low = 0;
    for (int i = 0; i < 32; i++) begin
      if (load_done === 1'b1) early_done++;
      if (load_ready !== 1'b1) ready_low++;
      load_valid = 1'b1; load_bit = w[i];
      @(negedge clk);
    end
    load_valid = 1'b0; load_bit = 1'b0;
    done_after = load_done;
    cnt_after  = minterm_cnt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q_valid = 1'b1; q_args = 5'd3; r_ready = 1'b1;
    #1;
    checks++;
    if (q_ready !== 1'b0) begin errors++; $display("FAIL reset_q_ready: got %0b want 0", q_ready); end
    @(negedge clk);
    checks++;
    if (r_valid !== 1'b0 || minterm_cnt !== '0 || load_ready !== 1'b0 || load_done !== 1'b0 || r_res !== 1'b0 || r_args !== '0) begin
      errors++;
      $display("FAIL reset_state: got rv=%0b mc=%0d lr=%0b ld=%0b res=%0b args=%0d want all 0",
               r_valid, minterm_cnt, load_ready, load_done, r_res, r_args);
    end
    q_valid = 1'b0;
  endtask

  task automatic test_load();
    int early, rlow; logic done; logic [N:0] mc;
    model_tbl = 32'h114689AD;
    load_word(model_tbl, 1'b0, early, rlow, done, mc);
    checks++;
    if (early !== 0 || rlow !== 0) begin errors++; $display("FAIL load_early: got early_done=%0d ready_low=%0d want 0 0", early, rlow); end
    checks++;
    if (done !== 1'b1 || mc !== 6'd13) begin errors++; $display("FAIL load_done_cnt: got done=%0b cnt=%0d want 1 13", done, mc); end
    @(negedge clk);
    r_ready = 1'b1;
    #1;
    checks++;
    if (load_done !== 1'b0 || load_ready !== 1'b0 || q_ready !== 1'b1 || minterm_cnt !== 6'd13) begin
      errors++;
      $display("FAIL load_ready_state: got ld=%0b lr=%0b qr=%0b mc=%0d want 0 0 1 13", load_done, load_ready, q_ready, minterm_cnt);
    end
  endtask

  task automatic test_sweep(input string name, input int unsigned qs[$]);
    resp_t e;
    r_ready = 1'b1;
    for (int k = 0; k < qs.size(); k++) begin
      @(negedge clk);
      if (k > 0) begin
        e = sbq.pop_front();
        checks++;
        if (r_valid !== 1'b1 || r_res !== e.res || r_args !== e.args) begin
          errors++;
          $display("FAIL %s_resp: got v=%0b res=%0b args=%0d want v=1 res=%0b args=%0d", name, r_valid, r_res, r_args, e.res, e.args);
        end
      end
      q_valid = 1'b1; q_args = N'(qs[k]);
      #1;
      checks++;
      if (q_ready !== 1'b1) begin errors++; $display("FAIL %s_q_ready: got %0b want 1", name, q_ready); end
      sbq.push_back('{res: model_tbl[qs[k]], args: N'(qs[k])});
    end
    @(negedge clk);
    q_valid = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (r_valid !== 1'b1 || r_res !== e.res || r_args !== e.args) begin
      errors++;
      $display("FAIL %s_last_resp: got v=%0b res=%0b args=%0d want v=1 res=%0b args=%0d", name, r_valid, r_res, r_args, e.res, e.args);
    end
    @(negedge clk);
    checks++;
    if (r_valid !== 1'b0) begin errors++; $display("FAIL %s_drain: got r_valid=%0b want 0", name, r_valid); end
  endtask

  task automatic test_back_to_back();
    int unsigned qs[$];
    qs = '{0, 1, 28, 31};
    test_sweep("b2b", qs);
  endtask

  task automatic test_backpressure();
    resp_t e;
    @(negedge clk);
    r_ready = 1'b0; q_valid = 1'b1; q_args = 5'd0;
    #1;
    checks++;
    if (q_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %0b want 1", q_ready); end
    sbq.push_back('{res: model_tbl[0], args: 5'd0});
    @(negedge clk);
    q_args = 5'd5;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (q_ready !== 1'b0 || r_valid !== 1'b1 || r_res !== 1'b1 || r_args !== 5'd0) begin
        errors++;
        $display("FAIL bp_hold%0d: got qr=%0b rv=%0b res=%0b args=%0d want 0 1 1 0", c, q_ready, r_valid, r_res, r_args);
      end
      @(negedge clk);
    end
    r_ready = 1'b1;
    #1;
    e = sbq.pop_front();
    checks++;
    if (q_ready !== 1'b1 || r_valid !== 1'b1 || r_res !== e.res || r_args !== e.args) begin
      errors++;
      $display("FAIL bp_release: got qr=%0b rv=%0b res=%0b args=%0d want 1 1 %0b %0d", q_ready, r_valid, r_res, r_args, e.res, e.args);
    end
    sbq.push_back('{res: model_tbl[5], args: 5'd5});
    @(negedge clk);
    q_valid = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (r_valid !== 1'b1 || r_res !== e.res || r_args !== e.args) begin
      errors++;
      $display("FAIL bp_next: got rv=%0b res=%0b args=%0d want 1 %0b %0d", r_valid, r_res, r_args, e.res, e.args);
    end
    @(negedge clk);
  endtask

  task automatic test_restart();
    int early, rlow; logic done; logic [N:0] mc;
    int unsigned qs[$];
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1; load_bit = 1'b1;
      @(negedge clk);
    end
    load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b1 || load_done !== 1'b0 || minterm_cnt !== '0 || q_ready !== 1'b0) begin
      errors++;
      $display("FAIL restart_partial: got lr=%0b ld=%0b mc=%0d qr=%0b want 1 0 0 0", load_ready, load_done, minterm_cnt, q_ready);
    end
    model_tbl = 32'hFFFFFFFF;
    load_word(model_tbl, 1'b0, early, rlow, done, mc);
    checks++;
    if (early !== 0 || rlow !== 0 || done !== 1'b1 || mc !== 6'd32) begin
      errors++;
      $display("FAIL restart_load: got early=%0d rlow=%0d done=%0b cnt=%0d want 0 0 1 32", early, rlow, done, mc);
    end
    qs = '{17};
    test_sweep("restart", qs);
  endtask

  task automatic test_collision();
    int early, rlow; logic done; logic [N:0] mc;
    int unsigned qs[$];
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_bit = 1'b1;
      @(negedge clk);
    end
    load_valid = 1'b0;
    model_tbl = 32'h00000000;
    load_word(model_tbl, 1'b1, early, rlow, done, mc);
    checks++;
    if (early !== 0 || rlow !== 0 || done !== 1'b1 || mc !== 6'd0) begin
      errors++;
      $display("FAIL collide_load: got early=%0d rlow=%0d done=%0b cnt=%0d want 0 0 1 0", early, rlow, done, mc);
    end
    // load bits presented while READY must not disturb the table
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      load_valid = 1'b1; load_bit = 1'b1;
    end
    @(negedge clk);
    load_valid = 1'b0;
    checks++;
    if (load_done !== 1'b0 || minterm_cnt !== '0 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL collide_idle_bits: got ld=%0b mc=%0d lr=%0b want 0 0 0", load_done, minterm_cnt, load_ready);
    end
    for (int i = 0; i < 32; i++) qs.push_back(i);
    test_sweep("zero_sweep", qs);
  endtask

  task automatic test_reset_midload();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1; load_bit = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; load_valid = 1'b0;
    q_valid = 1'b1; q_args = 5'd1;
    #1;
    checks++;
    if (load_ready !== 1'b0 || minterm_cnt !== '0 || q_ready !== 1'b0 || r_valid !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset: got lr=%0b mc=%0d qr=%0b rv=%0b want 0 0 0 0", load_ready, minterm_cnt, q_ready, r_valid);
    end
    @(negedge clk);
    q_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_bit = 1'b0;
    q_valid = 1'b0; q_args = '0; r_ready = 1'b0; model_tbl = '0;
    test_reset();
    test_load();
    test_back_to_back();
    test_backpressure();
    test_restart();
    test_collision();
    test_reset_midload();
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d entries want 0", sbq.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_lut_responder.md
Name: tt_lut_responder

Overview:
- Responder end of the truth-table query interface used by the function-sweep checkers.
- A checker drives args and samples res; this block is the sequential function provider on the other side of that interface.
- It is loaded serially with a 2**N_IN-bit truth table, counts the table's minterms (SDNF term count), then answers argument queries through a valid/ready request/response handshake.
- It sits between the table source (bench or config logic) and any sweep/compare engine.

Parameters:
- N_IN, 5, number of function inputs; table size TBL = 2**N_IN is a derived localparam.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  pulse: begin a new table load; invalidates the current table.
- load_valid  in  1  serial table bit valid.
- load_bit  in  1  table bit; first accepted bit = table[0] (args==0), LSB-first.
- load_ready  out  1  high while in LOAD.
- load_done  out  1  one-cycle pulse when the table becomes valid.
- minterm_cnt  out  N_IN+1  number of 1s in the loaded table (0..TBL).
- q_valid  in  1  query request valid.
- q_args  in  N_IN  query argument.
- q_ready  out  1  query accepted when q_valid & q_ready.
- r_valid  out  1  response valid.
- r_res  out  1  table[q_args] of the accepted query.
- r_args  out  N_IN  echo of the accepted q_args.
- r_ready  in  1  response consumer ready.

Behaviour:
- States: EMPTY (no valid table), LOAD, READY.
- Reset values: state EMPTY; table all 0; bit counter 0; minterm_cnt 0; load_ready 0; load_done 0; r_valid 0; r_res 0; r_args 0.
- EMPTY -> LOAD on load_start. LOAD -> READY when bit TBL-1 is accepted. READY -> LOAD on load_start.
- load_start in LOAD restarts the load: counter 0, running count 0, already-received bits discarded.
- In LOAD, a bit is accepted when load_valid=1. It is written to table[cnt], cnt increments, and the running count increments if load_bit=1.
- load_start and load_valid in the same cycle: load_start wins and the bit is discarded.
- load_valid outside LOAD is ignored.
- minterm_cnt updates only when the load completes, in the same cycle load_done is asserted (the cycle after the last bit is accepted). It holds its value until the next completed load. It is cleared to 0 on entering LOAD.
- q_ready = (state==READY) & (!r_valid | r_ready). It is combinational and 0 in EMPTY and LOAD.
- Query latency is 1 cycle: an accepted query sets r_valid=1 with r_res=table[q_args] and r_args=q_args on the next edge.
- The response register holds while r_valid & !r_ready.
- Throughput is 1 query/cycle when r_ready is held high.
- r_valid clears when r_ready=1 and no new query is accepted in that cycle.
- A response pending at load_start is still delivered unchanged. No new queries are accepted until READY.
- q_args wrap-around: all values 0..TBL-1 are legal, and there is no out-of-range case.
- rst mid-load or mid-response returns to the reset values immediately on that edge.

Decomposition:
- Shared package:
  - state encoding typedef {EMPTY, LOAD, READY};
  - default N_IN;
  - TBL localparam function.
- One natural sub-module: tt_loader (serial shift/index counter, running popcount, load_done generation).
- The query/response register stays in the top.

Test Plan:
- Reset, then q_valid=1 -> q_ready=0, r_valid stays 0, minterm_cnt=0.
- Load 0x114689AD LSB-first over 32 cycles -> load_done pulses once one cycle after bit 31; minterm_cnt=13; state READY.
- Back-to-back queries args=0,1,28,31 with r_ready=1 -> r_res=1,0,1,0 on consecutive cycles, with r_args echoed.
- Backpressure: query args=0, hold r_ready=0 for 3 cycles -> q_ready=0, r_res=1/r_args=0 held; release -> next query accepted.
- load_start after 10 bits, then a full load of 0xFFFFFFFF -> load_done only after 32 new bits; minterm_cnt=32; query 17 -> r_res=1.
- load_start and load_valid asserted together -> bit ignored; a 32-bit load of 0x00000000 then gives minterm_cnt=0 and all queries r_res=0.
